// File: rtl/iob_pfsm_prog_pkg.sv
// iob_pfsm_prog_pkg: shared state encoding and derived-size helpers for the
// iob_pfsm_prog LUT programmer.
package iob_pfsm_prog_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST_ON  = 3'd1,
    FETCH   = 3'd2,
    SEL     = 3'd3,
    MEM     = 3'd4,
    RST_OFF = 3'd5,
    DONE    = 3'd6
  } state_t;

  // Number of DATA_W-wide bus words needed to carry one LUT entry.
  function automatic int n_words(input int lut_w, input int data_w);
    return (lut_w + data_w - 32'sd1) / data_w;
  endfunction

  // Byte distance between consecutive MEMORY window words (power of two).
  function automatic int stride(input int data_w);
    return 32'sd1 << $clog2((data_w + 32'sd7) / 32'sd8);
  endfunction

  // Number of LUT entries, one per {state, input} combination.
  function automatic int n_entries(input int input_w, input int state_w);
    return 32'sd1 << (input_w + state_w);
  endfunction

endpackage

// File: rtl/iob_pfsm_prog_wsel.sv
// iob_pfsm_prog_wsel: picks bus word w out of a LUT entry, zero-padding the
// bits above the entry width.
module iob_pfsm_prog_wsel #(
  parameter int DATA_W     = 32'sd32,
  parameter int LUT_DATA_W = 32'sd3,
  parameter int N_WORDS    = 32'sd1,
  parameter int W_W        = 32'sd1
) (
  input  logic [LUT_DATA_W-1:0] entry_i,
  input  logic [W_W-1:0]        w_i,
  output logic [DATA_W-1:0]     word_o
);

  localparam int PAD_W = N_WORDS * DATA_W;

  logic [PAD_W-1:0] padded_s;

  // Widen the entry to a whole number of words, then slice word w.
  always_comb begin
    padded_s = PAD_W'(entry_i);
    if (int'(w_i) < N_WORDS) begin
      word_o = padded_s[int'(w_i)*DATA_W +: DATA_W];
    end else begin
      word_o = {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/iob_reg_r.sv
// iob_reg_r: plain register with clock enable and synchronous active-high
// reset to RST_VAL.
module iob_reg_r #(
  parameter int                DATA_W  = 32'sd1,
  parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  // Reset wins even with the clock enable low; otherwise load only when enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o <= RST_VAL;
    end else if (cke_i) begin
      data_o <= data_i;
    end else begin
      data_o <= data_o;
    end
  end

endmodule

// File: rtl/iob_pfsm_prog.sv
// iob_pfsm_prog: streams LUT entries into an iob_pfsm over its IOb slave port
// (SOFTRESET on, MEM_WORD_SELECT/MEMORY per word, SOFTRESET off).
// Optional feature macro: IOB_PFSM_PROG_ABORT_EN adds abort_i / error_o.
module iob_pfsm_prog
  import iob_pfsm_prog_pkg::*;
#(
  parameter int DATA_W         = 32'sd32,
  parameter int ADDR_W         = 32'sd12,
  parameter int STATE_W        = 32'sd2,
  parameter int INPUT_W        = 32'sd1,
  parameter int OUTPUT_W       = 32'sd1,
  parameter int SOFTRESET_ADDR = 32'sd0,
  parameter int WORD_SEL_ADDR  = 32'sd4,
  parameter int MEMORY_ADDR    = 32'sd256
) (
  input  logic                          clk_i,
  input  logic                          cke_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          done_o,
  input  logic                          lut_valid_i,
  input  logic [STATE_W+OUTPUT_W-1:0]   lut_data_i,
  output logic                          lut_ready_o,
`ifdef IOB_PFSM_PROG_ABORT_EN
  input  logic                          abort_i,
  output logic                          error_o,
`endif
  output logic                          iob_avalid_o,
  output logic [ADDR_W-1:0]             iob_addr_o,
  output logic [DATA_W-1:0]             iob_wdata_o,
  output logic [DATA_W/8-1:0]           iob_wstrb_o,
  input  logic                          iob_ready_i
);

  localparam int LUT_DATA_W = STATE_W + OUTPUT_W;
  localparam int N_WORDS    = n_words(LUT_DATA_W, DATA_W);
  localparam int N_ENTRIES  = n_entries(INPUT_W, STATE_W);
  localparam int STRIDE_SH  = $clog2(stride(DATA_W));
  localparam int E_W        = INPUT_W + STATE_W;
  localparam int W_W        = $clog2(N_WORDS + 32'sd1);
  localparam logic [E_W-1:0] E_LAST = E_W'(N_ENTRIES - 32'sd1);
  localparam logic [W_W-1:0] W_LAST = W_W'(N_WORDS - 32'sd1);

  logic [2:0]            state_bits_q;
  state_t                state_q, state_d;
  logic [E_W-1:0]        e_q, e_d;
  logic [W_W-1:0]        w_q, w_d;
  logic [LUT_DATA_W-1:0] entry_q, entry_d;
  logic [DATA_W-1:0]     word_s;
  logic [ADDR_W-1:0]     mem_addr_s;
  logic                  txn_s;
  logic                  abort_s;

  assign state_q = state_t'(state_bits_q);

  iob_reg_r #(.DATA_W(3), .RST_VAL(IDLE)) state_reg (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .data_i(state_d), .data_o(state_bits_q)
  );
  iob_reg_r #(.DATA_W(E_W), .RST_VAL({E_W{1'b0}})) e_reg (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .data_i(e_d), .data_o(e_q)
  );
  iob_reg_r #(.DATA_W(W_W), .RST_VAL({W_W{1'b0}})) w_reg (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .data_i(w_d), .data_o(w_q)
  );
  iob_reg_r #(.DATA_W(LUT_DATA_W), .RST_VAL({LUT_DATA_W{1'b0}})) entry_reg (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .data_i(entry_d), .data_o(entry_q)
  );

  iob_pfsm_prog_wsel #(
    .DATA_W(DATA_W), .LUT_DATA_W(LUT_DATA_W), .N_WORDS(N_WORDS), .W_W(W_W)
  ) wsel (
    .entry_i(entry_q), .w_i(w_q), .word_o(word_s)
  );

`ifdef IOB_PFSM_PROG_ABORT_EN
  logic error_q, error_d;
  logic abort_hit_s;

  iob_reg_r #(.DATA_W(1), .RST_VAL(1'b0)) error_reg (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .data_i(error_d), .data_o(error_q)
  );

  assign error_o = error_q;

  // Abort counts only while programming; once latched it steers the FSM to RST_OFF.
  always_comb begin
    abort_hit_s = abort_i && ((state_q == RST_ON) || (state_q == FETCH) ||
                              (state_q == SEL) || (state_q == MEM));
    abort_s     = abort_hit_s || error_q;
    if ((state_q == IDLE) && start_i) begin
      error_d = 1'b0;
    end else if (abort_hit_s) begin
      error_d = 1'b1;
    end else begin
      error_d = error_q;
    end
  end
`else
  assign abort_s = 1'b0;
`endif

  assign mem_addr_s = ADDR_W'(MEMORY_ADDR) + (ADDR_W'(e_q) << STRIDE_SH);
  assign txn_s      = iob_avalid_o && iob_ready_i;

  // Next-state and counter update; write states advance only on a handshake.
  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    w_d     = w_q;
    entry_d = entry_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RST_ON;
          e_d     = {E_W{1'b0}};
          w_d     = {W_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RST_ON: begin
        if (txn_s) begin
          state_d = abort_s ? RST_OFF : FETCH;
        end else begin
          state_d = RST_ON;
        end
      end
      FETCH: begin
        if (abort_s) begin
          state_d = RST_OFF;
        end else if (lut_valid_i) begin
          entry_d = lut_data_i;
          w_d     = {W_W{1'b0}};
          state_d = SEL;
        end else begin
          state_d = FETCH;
        end
      end
      SEL: begin
        if (txn_s) begin
          state_d = abort_s ? RST_OFF : MEM;
        end else begin
          state_d = SEL;
        end
      end
      MEM: begin
        if (!txn_s) begin
          state_d = MEM;
        end else if (abort_s) begin
          state_d = RST_OFF;
        end else if (w_q != W_LAST) begin
          w_d     = w_q + W_W'(1'b1);
          state_d = SEL;
        end else if (e_q == E_LAST) begin
          state_d = RST_OFF;
        end else begin
          e_d     = e_q + E_W'(1'b1);
          state_d = FETCH;
        end
      end
      RST_OFF: begin
        if (txn_s) begin
          state_d = DONE;
        end else begin
          state_d = RST_OFF;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus request and status outputs decoded from the registered state.
  always_comb begin
    iob_avalid_o = 1'b0;
    iob_addr_o   = {ADDR_W{1'b0}};
    iob_wdata_o  = {DATA_W{1'b0}};
    iob_wstrb_o  = {(DATA_W/8){1'b0}};
    lut_ready_o  = 1'b0;
    busy_o       = (state_q != IDLE);
    done_o       = (state_q == DONE);
    case (state_q)
      RST_ON: begin
        iob_avalid_o = 1'b1;
        iob_addr_o   = ADDR_W'(SOFTRESET_ADDR);
        iob_wdata_o  = DATA_W'(1'b1);
        iob_wstrb_o  = {(DATA_W/8){1'b1}};
      end
      FETCH: begin
        lut_ready_o = lut_valid_i && !abort_s;
      end
      SEL: begin
        iob_avalid_o = 1'b1;
        iob_addr_o   = ADDR_W'(WORD_SEL_ADDR);
        iob_wdata_o  = DATA_W'(w_q);
        iob_wstrb_o  = {(DATA_W/8){1'b1}};
      end
      MEM: begin
        iob_avalid_o = 1'b1;
        iob_addr_o   = mem_addr_s;
        iob_wdata_o  = word_s;
        iob_wstrb_o  = {(DATA_W/8){1'b1}};
      end
      RST_OFF: begin
        iob_avalid_o = 1'b1;
        iob_addr_o   = ADDR_W'(SOFTRESET_ADDR);
        iob_wdata_o  = {DATA_W{1'b0}};
        iob_wstrb_o  = {(DATA_W/8){1'b1}};
      end
      default: begin
        iob_avalid_o = 1'b0;
      end
    endcase
  end

endmodule
